pen_smp_timer: RTL and testbench
================================

# pen_smp_timer

Pen sample scheduler that consumes the 16-bit pen sample-speed register driven by the CPU-side PIO. It divides the system clock into sample periods, requests a conversion from the touch ADC controller with a req/ack handshake, and buffers the returned coordinate words in a small show-ahead FIFO. The CPU, or a DMA-side reader, drains the FIFO. It sits between the speed PIO (upstream) and the touch ADC interface (downstream).

## Interface
- PRESCALE, 1000: clk cycles per speed unit (≥2).
- DW, 24: ADC sample word width ({y[11:0], x[11:0]}).
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- smp_speed  in  16  sample period in prescale units; value 0 is treated as 1.
- enable  in  1  global sampling enable.
- pen_down  in  1  pen contact, already synchronous to clk.
- adc_req  out  1  conversion request; level, held until ack.
- adc_ack  in  1  one-cycle conversion-done strobe; adc_data valid in the same cycle.
- adc_data  in  DW  conversion result.
- rd_en  in  1  pop FIFO head.
- rd_data  out  DW (+16, see Configuration)  FIFO head, show-ahead.
- fifo_empty  out  1
- fifo_full  out  1
- fifo_count  out  log2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: a sample was dropped.
- ovf_clr  in  1  clears overflow.
- irq  out  1  equals ~fifo_empty.

## Operation
- Run condition: `run = enable & pen_down`.
  - While run is low, the prescale and period counters are held at 0.
  - A request already in flight still completes.
- Prescaler: counts 0..PRESCALE-1 while run is high. Each wrap produces a one-cycle tick.
- Period counter:
  - Loads `P = max(smp_speed,1)` when run rises and at each expiry.
  - Decrements on each tick; expiry occurs on the tick where it reaches 1.
  - smp_speed is sampled only at load. Changes take effect from the next period.
- FSM states: IDLE and REQ.
  - IDLE→REQ on expiry; adc_req goes to 1.
  - REQ→IDLE on adc_ack=1; adc_data is captured into the FIFO and adc_req goes to 0.
  - An expiry while in REQ is dropped, and overflow is set (late conversion).
  - adc_ack while in IDLE is ignored.
- FIFO write on a captured sample:
  - If not full, the sample is written.
  - If full and rd_en=1 in the same cycle, both the pop and the push occur. No overflow; count is unchanged.
  - If full and no rd_en, the sample is dropped and overflow is set.
- FIFO read: rd_en when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- Overflow: an ovf_clr in the same cycle as a new overflow event leaves overflow=1 (set wins).
- Reset values: adc_req=0, overflow=0, fifo_empty=1, fifo_full=0, fifo_count=0, irq=0, rd_data=0, FSM=IDLE, counters=0.
- Reset mid-handshake: adc_req drops immediately (asynchronous). The ADC side must tolerate an aborted request.

## Timing
- First request: adc_req rises on the clk edge after the P-th tick following run rising. That edge is P·PRESCALE cycles after the first run-high edge.
- Steady state: one request every P·PRESCALE cycles, provided ack returns within a period.
- Ack to data:
  - The entry is written on the ack edge.
  - fifo_empty, fifo_count, irq and rd_data update in that edge's output, one cycle after ack is presented.
- Read: the rd_en edge advances the head. The next entry appears on rd_data the same edge.
- Registered outputs: adc_req, overflow, fifo_* and irq are registered. rd_data is a registered memory read or mux of the head.

## Configuration
- PEN_SMP_TIMESTAMP_EN defined:
  - A free-running 16-bit tick counter (counts prescale ticks, wraps at 0xFFFF) is captured at the ack edge.
  - It is stored in each FIFO entry; rd_data = {timestamp[15:0], adc_data}, width DW+16.
- Not defined: rd_data width is DW and no timestamp logic exists.

## Test plan
- Reset value: reset=1 then 0, enable=1, pen_down=1, smp_speed=1, PRESCALE=4 → adc_req first rises 4 cycles after run; all outputs at reset values before that.
- Steady sampling: smp_speed=3, ack 2 cycles after each req with adc_data=0x123456 → req period 12 cycles, fifo_count increments, rd_data=0x123456, irq=1.
- Speed zero and speed change: smp_speed=0 → period 4 cycles; change to 5 mid-period → current period unchanged, next period 20 cycles.
- Overflow:
  - FIFO_DEPTH=4, no reads, 5 acks → fifo_full=1, count=4, overflow=1, 5th sample lost.
  - Full + rd_en on the ack cycle → count stays 4, no overflow.
  - ovf_clr → overflow=0.
- Late ack: ack withheld for 2 periods → one request only, overflow=1; after ack, next request on the following expiry.
- Run drop and reset: pen_down falls during REQ → ack still captured, no new req; reset asserted during REQ → adc_req=0 same cycle, FIFO empty.

Source files
------------

// File: rtl/pen_smp_timer_if.sv
// Bus bundle for pen_smp_timer: ADC req/ack handshake plus the FIFO read side.
// PEN_SMP_TIMESTAMP_EN widens rd_data by a 16-bit timestamp.
interface pen_smp_timer_if #(
    parameter int DW         = 24,
    parameter int FIFO_DEPTH = 4
);
`ifdef PEN_SMP_TIMESTAMP_EN
    localparam int RW = DW + 16;
`else
    localparam int RW = DW;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          adc_req;
    logic          adc_ack;
    logic [DW-1:0] adc_data;
    logic          rd_en;
    logic [RW-1:0] rd_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          ovf_clr;
    logic          irq;

    modport master (
        output adc_req,
        input  adc_ack,
        input  adc_data,
        input  rd_en,
        output rd_data,
        output fifo_empty,
        output fifo_full,
        output fifo_count,
        output overflow,
        input  ovf_clr,
        output irq
    );

    modport slave (
        input  adc_req,
        output adc_ack,
        output adc_data,
        output rd_en,
        input  rd_data,
        input  fifo_empty,
        input  fifo_full,
        input  fifo_count,
        input  overflow,
        output ovf_clr,
        input  irq
    );
endinterface

// File: rtl/pen_smp_timer.sv
// Pen sample scheduler: prescaled period timer, ADC req/ack FSM and show-ahead sample FIFO.
// Optional PEN_SMP_TIMESTAMP_EN stores a 16-bit prescale-tick timestamp with each sample.
module pen_smp_timer #(
    parameter int PRESCALE   = 1000,
    parameter int DW         = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            smp_speed,
    input  logic                   enable,
    input  logic                   pen_down,
    pen_smp_timer_if.master        bus
);
`ifdef PEN_SMP_TIMESTAMP_EN
    localparam int RW = DW + 16;
`else
    localparam int RW = DW;
`endif
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    logic          run_s, run_d_r, run_rise_s, tick_r, expiry_s;
    logic [PW-1:0] pre_cnt_r;
    logic [15:0]   per_cnt_r, per_load_s;
    state_t        state_r, state_nxt_s;
    logic          cap_s;
    logic [RW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          push_s, pop_s, full_s, empty_s, ovf_set_s;
    logic [RW-1:0] din_s, head_nxt_s, rd_data_r;
    logic          overflow_r, empty_r, full_r, irq_r;

    assign run_s      = enable & pen_down;
    assign run_rise_s = run_s & ~run_d_r;
    assign per_load_s = (smp_speed == 16'd0) ? 16'd1 : smp_speed;
    // tick_r is a registered pulse, so expiry lands one edge after the P-th prescale wrap
    assign expiry_s   = run_s & ~run_rise_s & tick_r & (per_cnt_r == 16'd1);

`ifdef PEN_SMP_TIMESTAMP_EN
    logic [15:0] ts_cnt_r;

    // Free-running prescale-tick counter used as the sample timestamp
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_r <= 16'd0;
        end else if (tick_r) begin
            ts_cnt_r <= ts_cnt_r + 16'd1;
        end else begin
            ts_cnt_r <= ts_cnt_r;
        end
    end

    assign din_s = {ts_cnt_r, bus.adc_data};
`else
    assign din_s = bus.adc_data;
`endif

    // Prescaler and run-edge tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_d_r   <= 1'b0;
            pre_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            run_d_r <= run_s;
            if (!run_s) begin
                pre_cnt_r <= '0;
                tick_r    <= 1'b0;
            end else if (pre_cnt_r == PRE_MAX) begin
                pre_cnt_r <= '0;
                tick_r    <= 1'b1;
            end else begin
                pre_cnt_r <= pre_cnt_r + PW'(1);
                tick_r    <= 1'b0;
            end
        end
    end

    // Period counter: loads on run rise and on expiry, smp_speed sampled only then
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt_r <= 16'd0;
        end else if (!run_s) begin
            per_cnt_r <= 16'd0;
        end else if (run_rise_s) begin
            per_cnt_r <= per_load_s;
        end else if (tick_r) begin
            per_cnt_r <= (per_cnt_r == 16'd1) ? per_load_s : (per_cnt_r - 16'd1);
        end else begin
            per_cnt_r <= per_cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and sample capture
    always_comb begin
        state_nxt_s = state_r;
        cap_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (expiry_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.adc_ack) begin
                    state_nxt_s = ST_IDLE;
                    cap_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign full_s       = (count_r == DEPTH_C);
    assign empty_s      = (count_r == '0);
    assign pop_s        = bus.rd_en & ~empty_s;
    assign push_s       = cap_s & (~full_s | bus.rd_en);
    assign ovf_set_s    = (expiry_s & (state_r == ST_REQ)) | (cap_s & full_s & ~bus.rd_en);
    assign rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

    // FIFO occupancy and the head value visible after this edge
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = '0;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // a slot being written this edge is not yet in mem_r, so forward din
        if (count_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = din_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din_s;
        end
    end

    // FIFO pointers, count and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_data_r  <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            irq_r      <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            rd_data_r  <= head_nxt_s;
            empty_r    <= (count_nxt_s == '0);
            full_r     <= (count_nxt_s == DEPTH_C);
            irq_r      <= (count_nxt_s != '0);
            overflow_r <= ovf_set_s ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_r);
        end
    end

    assign bus.adc_req    = (state_r == ST_REQ);
    assign bus.rd_data    = rd_data_r;
    assign bus.fifo_empty = empty_r;
    assign bus.fifo_full  = full_r;
    assign bus.fifo_count = count_r;
    assign bus.overflow   = overflow_r;
    assign bus.irq        = irq_r;
endmodule

// File: tb/tb_pen_smp_timer.sv
// Directed bench for pen_smp_timer: an event-time model (expiry edges computed as
// absolute edge numbers, FIFO as a queue) checked every cycle, plus literal timing checks.
module tb_pen_smp_timer;
    localparam int PRE   = 4;
    localparam int DW    = 24;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] smp_speed;
    logic        enable;
    logic        pen_down;

    pen_smp_timer_if #(.DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

    pen_smp_timer #(.PRESCALE(PRE), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .smp_speed(smp_speed),
        .enable   (enable),
        .pen_down (pen_down),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int            m_edge = 0;
    bit            m_run_prev;
    int            m_next_exp;
    bit            m_req;
    bit            m_ovf;
    logic [DW-1:0] m_q [$];
    bit            chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run_prev = 1'b0;
        m_next_exp = -1;
        m_req      = 1'b0;
        m_ovf      = 1'b0;
        m_q.delete();
    endfunction

    // One clock edge of the spec-level model, evaluated with the inputs seen at that edge
    function automatic void model_step();
        bit run, expiry, cap, full, ovf_set;
        int p;
        m_edge++;
        if (reset) begin
            model_reset();
            return;
        end
        run     = enable & pen_down;
        expiry  = 1'b0;
        ovf_set = 1'b0;
        p = (smp_speed == 16'd0) ? 1 : int'(smp_speed);
        if (!run) begin
            m_next_exp = -1;
        end else if (!m_run_prev) begin
            m_next_exp = m_edge + p * PRE;
        end else if (m_edge == m_next_exp) begin
            expiry     = 1'b1;
            m_next_exp = m_edge + p * PRE;
        end
        m_run_prev = run;
        cap  = m_req && bus.adc_ack;
        full = (m_q.size() == DEPTH);
        if (expiry && m_req) ovf_set = 1'b1;
        if (m_req) m_req = !bus.adc_ack;
        else       m_req = expiry;
        if (bus.rd_en && m_q.size() > 0) void'(m_q.pop_front());
        if (cap) begin
            if (!full || bus.rd_en) m_q.push_back(bus.adc_data);
            else                    ovf_set = 1'b1;
        end
        if (ovf_set)          m_ovf = 1'b1;
        else if (bus.ovf_clr) m_ovf = 1'b0;
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("adc_req",    32'(bus.adc_req),    32'(m_req));
            check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
            check("fifo_empty", 32'(bus.fifo_empty), 32'(m_q.size() == 0));
            check("fifo_full",  32'(bus.fifo_full),  32'(m_q.size() == DEPTH));
            check("irq",        32'(bus.irq),        32'(m_q.size() != 0));
            check("overflow",   32'(bus.overflow),   32'(m_ovf));
            if (m_q.size() > 0) check("rd_data", 32'(bus.rd_data[DW-1:0]), 32'(m_q[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_rise(output int edge_no);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (bus.adc_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("req_timeout", {31'd0, got}, 32'd1);
        edge_no = m_edge;
    endtask

    task automatic ack_after(input int n, input logic [DW-1:0] data);
        repeat (n) cyc();
        bus.adc_ack  = 1'b1;
        bus.adc_data = data;
        cyc();
        bus.adc_ack  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, t4;
        smp_speed    = 16'd1;
        enable       = 1'b1;
        pen_down     = 1'b1;
        bus.adc_ack  = 1'b0;
        bus.adc_data = '0;
        bus.rd_en    = 1'b0;
        bus.ovf_clr  = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_adc_req",  32'(bus.adc_req),    32'd0);
        check("rst_empty",    32'(bus.fifo_empty), 32'd1);
        check("rst_full",     32'(bus.fifo_full),  32'd0);
        check("rst_count",    32'(bus.fifo_count), 32'd0);
        check("rst_irq",      32'(bus.irq),        32'd0);
        check("rst_rd_data",  32'(bus.rd_data),    32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        t0 = m_edge;
        check("req_low_after_run", 32'(bus.adc_req), 32'd0);
        wait_rise(t1);
        check("first_req_latency", 32'(t1 - t0), 32'd4);

        // Steady sampling at speed 3
        smp_speed = 16'd3;
        do_reset();
        wait_rise(t1);
        ack_after(2, 24'h123456);
        check("steady_count1", 32'(bus.fifo_count), 32'd1);
        check("steady_rd",     32'(bus.rd_data[DW-1:0]), 32'h00123456);
        check("steady_irq",    32'(bus.irq), 32'd1);
        wait_rise(t2);
        check("period_speed3", 32'(t2 - t1), 32'd12);
        ack_after(2, 24'h123456);
        check("steady_count2", 32'(bus.fifo_count), 32'd2);

        // Speed zero, then a change mid-period
        smp_speed = 16'd0;
        do_reset();
        wait_rise(t1);
        ack_after(0, 24'h000111);
        wait_rise(t2);
        check("period_speed0", 32'(t2 - t1), 32'd4);
        ack_after(0, 24'h000222);
        smp_speed = 16'd5;
        wait_rise(t3);
        check("period_unchanged", 32'(t3 - t2), 32'd4);
        ack_after(0, 24'h000333);
        wait_rise(t4);
        check("period_speed5", 32'(t4 - t3), 32'd20);

        // Overflow: five samples into a four-deep FIFO
        smp_speed = 16'd1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_rise(t1);
            ack_after(0, 24'(i + 1));
        end
        check("ovf_count", 32'(bus.fifo_count), 32'd4);
        check("ovf_full",  32'(bus.fifo_full),  32'd1);
        check("ovf_set",   32'(bus.overflow),   32'd1);
        check("ovf_head",  32'(bus.rd_data[DW-1:0]), 32'd1);
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        wait_rise(t1);
        bus.adc_ack  = 1'b1;
        bus.adc_data = 24'h0000AA;
        bus.rd_en    = 1'b1;
        cyc();
        bus.adc_ack = 1'b0;
        bus.rd_en   = 1'b0;
        check("full_rw_count", 32'(bus.fifo_count), 32'd4);
        check("full_rw_ovf",   32'(bus.overflow),   32'd0);
        check("full_rw_head",  32'(bus.rd_data[DW-1:0]), 32'd2);
        bus.rd_en = 1'b1;
        repeat (5) cyc();
        bus.rd_en = 1'b0;
        check("drain_empty", 32'(bus.fifo_empty), 32'd1);

        // Late ack held over two periods
        smp_speed = 16'd1;
        do_reset();
        wait_rise(t1);
        repeat (8) cyc();
        check("late_req_held", 32'(bus.adc_req),  32'd1);
        check("late_ovf",      32'(bus.overflow), 32'd1);
        ack_after(0, 24'hBEEF01);
        wait_rise(t2);
        check("late_next_req", 32'(t2 - t1), 32'd12);

        // Run drop during REQ, then reset during REQ
        do_reset();
        wait_rise(t1);
        pen_down = 1'b0;
        ack_after(1, 24'h0ABCDE);
        check("drop_captured", 32'(bus.fifo_count), 32'd1);
        repeat (12) cyc();
        check("drop_no_req", 32'(bus.adc_req), 32'd0);
        pen_down = 1'b1;
        wait_rise(t2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_req_drop", 32'(bus.adc_req),    32'd0);
        check("async_empty",    32'(bus.fifo_empty), 32'd1);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
